hazard_ctrl_sb: RTL and testbench

Next-generation RISC-V pipeline hazard controller with a scoreboard for one multi-cycle unit (MDU, mul/div), alongside the existing M/W forwarding, load-use and branch-flush logic. It sits beside the F/D/E/M/W pipeline registers and drives their stall and flush enables plus the E-stage operand muxes. It is parametrised in register-address width and MDU latency, and keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_fwd_sel.sv | 27 ++
 rtl/hazard_ctrl_sb.sv | 142 ++++++++++++++
 tb/tb_hazard_ctrl_sb.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: forwarding selects, MDU scoreboard
// states and the hard-wired zero register index.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

  localparam int unsigned X0 = 0;

endpackage

// File: rtl/hazard_fwd_sel.sv
// E-stage operand bypass select for one source register; M wins over W
// because it holds the younger result.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] rs_e_i,
  input  logic [AW-1:0] rd_m_i,
  input  logic [AW-1:0] rd_w_i,
  input  logic          reg_write_m_i,
  input  logic          reg_write_w_i,
  output fwd_sel_t      fwd_sel_o
);

  logic hit_m, hit_w;

  assign hit_m = reg_write_m_i && (rd_m_i == rs_e_i) && (rd_m_i != AW'(X0));
  assign hit_w = reg_write_w_i && (rd_w_i == rs_e_i) && (rd_w_i != AW'(X0));

  always_comb begin
    fwd_sel_o = FWD_NONE;
    if (hit_m)      fwd_sel_o = FWD_M;
    else if (hit_w) fwd_sel_o = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Pipeline hazard controller: M/W forwarding, load-use and branch flush,
// plus a single-entry scoreboard tracking one outstanding MDU op.
module hazard_ctrl_sb
  import hazard_pkg::*;
#(
  parameter int AW          = 5,
  parameter int MDU_MAX_LAT = 34,
  parameter int TMR_W       = 6,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rs1_d,
  input  logic [AW-1:0]    rs2_d,
  input  logic [AW-1:0]    rd_d,
  input  logic             reg_write_d,
  input  logic             mdu_op_d,
  input  logic [AW-1:0]    rs1_e,
  input  logic [AW-1:0]    rs2_e,
  input  logic [AW-1:0]    rd_e,
  input  logic             mem_read_e,
  input  logic             mdu_start_e,
  input  logic             mispredict_e,
  input  logic [AW-1:0]    rd_m,
  input  logic [AW-1:0]    rd_w,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             mdu_done,
  output logic [1:0]       forward_ae,
  output logic [1:0]       forward_be,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic             mdu_busy,
  output logic             mdu_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int NOPS = 2;
  localparam logic [AW-1:0] ZR = AW'(X0);

  logic [NOPS-1:0][AW-1:0] rs_e;
  fwd_sel_t [NOPS-1:0]     fwd_sel;

  assign rs_e[0] = rs1_e;
  assign rs_e[1] = rs2_e;

  for (genvar g = 0; g < NOPS; g++) begin : g_fwd
    hazard_fwd_sel #(.AW(AW)) u_fwd (
      .rs_e_i        (rs_e[g]),
      .rd_m_i        (rd_m),
      .rd_w_i        (rd_w),
      .reg_write_m_i (reg_write_m),
      .reg_write_w_i (reg_write_w),
      .fwd_sel_o     (fwd_sel[g])
    );
  end

  assign forward_ae = fwd_sel[0];
  assign forward_be = fwd_sel[1];

  mdu_state_t       state_q, state_d;
  logic [AW-1:0]    busy_rd_q, busy_rd_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A result landing this cycle is visible through the write-first regfile,
  // so the pending window closes on the mdu_done cycle itself.
  logic pending, load_use, raw_busy, raw_start, waw, struct_h, stall;

  assign pending   = (state_q == BUSY) && !mdu_done;
  assign load_use  = mem_read_e && (rd_e != ZR) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign raw_busy  = pending && (busy_rd_q != ZR) &&
                     ((busy_rd_q == rs1_d) || (busy_rd_q == rs2_d));
  assign raw_start = mdu_start_e && (rd_e != ZR) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign waw       = reg_write_d && (rd_d != ZR) && (rd_d == busy_rd_q) && pending;
  assign struct_h  = mdu_op_d && (pending || mdu_start_e);
  assign stall     = load_use || raw_busy || raw_start || waw || struct_h;

  assign stall_f = stall && !mispredict_e;
  assign stall_d = stall && !mispredict_e;
  assign flush_e = stall_d || mispredict_e;
  assign flush_d = mispredict_e;

  assign mdu_busy     = (state_q == BUSY);
  assign mdu_timeout  = timeout_q;
  assign stall_cycles = cnt_q;

  always_comb begin
    state_d   = state_q;
    busy_rd_d = busy_rd_q;
    timer_d   = timer_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (mdu_start_e) begin
          state_d   = BUSY;
          busy_rd_d = rd_e;
          timer_d   = '0;
        end
      end
      BUSY: begin
        if (timer_q >= TMR_W'(MDU_MAX_LAT)) timeout_d = 1'b1;
        if (mdu_done && mdu_start_e) begin
          busy_rd_d = rd_e;
          timer_d   = '0;
        end else if (mdu_done) begin
          state_d   = IDLE;
          busy_rd_d = '0;
          timer_d   = '0;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_d && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_rd_q <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_rd_q <= busy_rd_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Directed bench for hazard_ctrl_sb: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_hazard_ctrl_sb;

  localparam int AW = 5;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic reg_write_d, mdu_op_d, mem_read_e, mdu_start_e, mispredict_e;
  logic reg_write_m, reg_write_w, mdu_done;
  logic [1:0] forward_ae, forward_be;
  logic stall_f, stall_d, flush_d, flush_e, mdu_busy, mdu_timeout;
  logic [CNT_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_ctrl_sb #(.AW(AW), .MDU_MAX_LAT(34), .TMR_W(6), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .reg_write_d(reg_write_d),
    .mdu_op_d(mdu_op_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .mem_read_e(mem_read_e), .mdu_start_e(mdu_start_e), .mispredict_e(mispredict_e),
    .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mdu_done(mdu_done),
    .forward_ae(forward_ae), .forward_be(forward_be),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .mdu_busy(mdu_busy), .mdu_timeout(mdu_timeout), .stall_cycles(stall_cycles)
  );

  typedef struct {
    string      tag;
    logic [1:0] fa, fb;
    logic       sf, sd, fd, fe, bz, to;
    int         sc;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".forward_ae"},   forward_ae,   e.fa);
      chk({e.tag, ".forward_be"},   forward_be,   e.fb);
      chk({e.tag, ".stall_f"},      stall_f,      e.sf);
      chk({e.tag, ".stall_d"},      stall_d,      e.sd);
      chk({e.tag, ".flush_d"},      flush_d,      e.fd);
      chk({e.tag, ".flush_e"},      flush_e,      e.fe);
      chk({e.tag, ".mdu_busy"},     mdu_busy,     e.bz);
      chk({e.tag, ".mdu_timeout"},  mdu_timeout,  e.to);
      chk({e.tag, ".stall_cycles"}, stall_cycles, e.sc);
    end
  end

  task automatic ex(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                    input logic sf, input logic sd, input logic fd, input logic fe,
                    input logic bz, input logic to, input int sc);
    exp_t e;
    e.tag = tag; e.fa = fa; e.fb = fb; e.sf = sf; e.sd = sd;
    e.fd = fd; e.fe = fe; e.bz = bz; e.to = to; e.sc = sc;
    sb.push_back(e);
  endtask

  task automatic clr();
    rs1_d = '0; rs2_d = '0; rd_d = '0; reg_write_d = 0; mdu_op_d = 0;
    rs1_e = '0; rs2_e = '0; rd_e = '0; mem_read_e = 0; mdu_start_e = 0;
    mispredict_e = 0; rd_m = '0; rd_w = '0; reg_write_m = 0; reg_write_w = 0;
    mdu_done = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    clr(); rst_n = 0;
    #1 ex("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); rst_n = 1;

    // forwarding
    clr(); rd_m = 5; rd_w = 5; reg_write_m = 1; reg_write_w = 1; rs1_e = 5;
    ex("fwd_m_prio", 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0); tick();
    reg_write_m = 0; rs2_e = 5;
    ex("fwd_w", 2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0); tick();
    clr(); reg_write_m = 1; reg_write_w = 1;
    ex("fwd_x0", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0); tick();
    clr(); rd_m = 3; rd_w = 3; reg_write_m = 1; reg_write_w = 1; rs1_e = 3; rs2_e = 3;
    ex("fwd_both_m", 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0); tick();

    // load-use
    clr(); mem_read_e = 1; rd_e = 7; rs2_d = 7;
    ex("load_use", 0, 0, 1, 1, 0, 1, 0, 0, 0); tick();
    clr();
    ex("load_use_after", 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    clr(); mem_read_e = 1;
    ex("load_x0", 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();

    // MDU RAW / structural / WAW
    clr(); mdu_start_e = 1; rd_e = 9; rs1_d = 9;
    ex("mdu_start_raw", 0, 0, 1, 1, 0, 1, 0, 0, 1); tick();
    clr(); rs1_d = 9;
    ex("mdu_busy_raw1", 0, 0, 1, 1, 0, 1, 1, 0, 2); tick();
    clr(); rs2_d = 9;
    ex("mdu_busy_raw2", 0, 0, 1, 1, 0, 1, 1, 0, 3); tick();
    clr(); mdu_op_d = 1;
    ex("mdu_struct", 0, 0, 1, 1, 0, 1, 1, 0, 4); tick();
    clr(); reg_write_d = 1; rd_d = 9;
    ex("mdu_waw", 0, 0, 1, 1, 0, 1, 1, 0, 5); tick();
    clr(); rs1_d = 4;
    ex("mdu_indep", 0, 0, 0, 0, 0, 0, 1, 0, 6); tick();
    clr(); rs1_d = 9; mdu_done = 1;
    ex("mdu_done_cyc", 0, 0, 0, 0, 0, 0, 1, 0, 6); tick();
    clr(); rs1_d = 9;
    ex("mdu_idle", 0, 0, 0, 0, 0, 0, 0, 0, 6); tick();

    // mispredict beats a load-use stall
    clr(); mem_read_e = 1; rd_e = 7; rs1_d = 7; mispredict_e = 1;
    ex("mispredict", 0, 0, 0, 0, 1, 1, 0, 0, 6); tick();

    // back-to-back MDU: done + start relatches busy_rd
    clr(); mdu_start_e = 1; rd_e = 10;
    ex("b2b_start", 0, 0, 0, 0, 0, 0, 0, 0, 6); tick();
    clr(); mdu_done = 1; mdu_start_e = 1; rd_e = 11;
    ex("b2b_relatch", 0, 0, 0, 0, 0, 0, 1, 0, 6); tick();
    clr(); rs2_d = 11;
    ex("b2b_new_rd", 0, 0, 1, 1, 0, 1, 1, 0, 6); tick();
    clr(); rs2_d = 10;
    ex("b2b_old_rd", 0, 0, 0, 0, 0, 0, 1, 0, 7); tick();
    clr(); mdu_done = 1;
    ex("b2b_done", 0, 0, 0, 0, 0, 0, 1, 0, 7); tick();

    // timeout
    clr(); mdu_start_e = 1; rd_e = 12;
    ex("to_start", 0, 0, 0, 0, 0, 0, 0, 0, 7); tick();
    clr();
    for (int i = 0; i < 40; i++) begin
      if (i == 5) ex("to_early", 0, 0, 0, 0, 0, 0, 1, 0, 7);
      tick();
    end
    ex("to_set", 0, 0, 0, 0, 0, 0, 1, 1, 7); tick();
    mdu_done = 1;
    ex("to_done", 0, 0, 0, 0, 0, 0, 1, 1, 7); tick();
    clr();
    ex("to_sticky", 0, 0, 0, 0, 0, 0, 0, 1, 7); tick();

    // reset mid-op
    clr(); mdu_start_e = 1; rd_e = 13;
    ex("rst_start", 0, 0, 0, 0, 0, 0, 0, 1, 7); tick();
    clr();
    ex("rst_busy", 0, 0, 0, 0, 0, 0, 1, 1, 7); tick();
    rst_n = 0;
    ex("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    rst_n = 1; mdu_done = 1; rs1_d = 13;
    ex("rst_late_done", 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    clr(); rs1_d = 13;
    ex("rst_after", 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();

    @(negedge clk); #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
